// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage: PC, single-outstanding imem fetch, IF/ID register (optional FETCH_MISALIGN_CHK_EN)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        instr_misalign
`endif
);

    localparam logic [2:0] S_REQ   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [2:0] S_FAULT = 3'd4;
`endif

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        outstanding;
    logic        accept;
    logic [31:0] redirect_target;
    logic        resp_load;
    logic        resp_hold;

`ifdef FETCH_MISALIGN_CHK_EN
    logic        redirect_misalign;
    assign redirect_target   = redirect_pc;
    assign redirect_misalign = |redirect_pc[1:0];
`else
    logic        unused_redirect_low;
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

    // A redirect withdraws any pending request in the same cycle.
    assign imem_req_valid = (state == S_REQ) && !redirect_valid && !rst;
    assign imem_addr      = {pc[31:2], 2'b00};
    assign accept         = imem_req_valid && imem_req_ready;

    // A returning word goes straight to IF/ID when decode can take it or IF/ID is empty.
    assign resp_load = (state == S_WAIT) && imem_resp_valid && (!stall || !instr_valid);
    assign resp_hold = (state == S_WAIT) && imem_resp_valid && stall && instr_valid;

    // Next-state selection; redirect outranks everything else.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_misalign)
                state_nxt = S_FAULT;
            else
`endif
            if (outstanding && !imem_resp_valid)
                state_nxt = S_DRAIN;
            else
                state_nxt = S_REQ;
        end else begin
            case (state)
                S_REQ:   if (accept) state_nxt = S_WAIT;
                S_WAIT:  if (resp_load) state_nxt = S_REQ;
                         else if (resp_hold) state_nxt = S_HOLD;
                S_HOLD:  if (!stall) state_nxt = S_REQ;
                S_DRAIN: if (imem_resp_valid) state_nxt = S_REQ;
`ifdef FETCH_MISALIGN_CHK_EN
                S_FAULT: state_nxt = S_FAULT;
`endif
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // Fetch control: PC, outstanding-request tracking and the one-entry hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            hold_instr  <= NOP_INSTR;
            hold_pc     <= RESET_PC;
            outstanding <= 1'b0;
        end else begin
            state <= state_nxt;
            if (imem_resp_valid)
                outstanding <= 1'b0;
            if (accept)
                outstanding <= 1'b1;
            if (redirect_valid)
                pc <= redirect_target;
            else if (accept)
                pc <= pc + 32'd4;
            if (accept)
                req_pc <= pc;
            if (resp_hold && !redirect_valid) begin
                hold_instr <= imem_rdata;
                hold_pc    <= req_pc;
            end
        end
    end

    // IF/ID pipeline register: flush on redirect, hold on stall, bubble when nothing new.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr          <= NOP_INSTR;
            instr_pc       <= RESET_PC;
            instr_valid    <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            instr_misalign <= 1'b0;
`endif
        end else if (redirect_valid) begin
            instr          <= NOP_INSTR;
            instr_valid    <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            instr_misalign <= 1'b0;
`endif
        end else if (resp_load) begin
            instr          <= imem_rdata;
            instr_pc       <= req_pc;
            instr_valid    <= 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
            instr_misalign <= 1'b0;
`endif
        end else if (state == S_HOLD && !stall) begin
            instr          <= hold_instr;
            instr_pc       <= hold_pc;
            instr_valid    <= 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
            instr_misalign <= 1'b0;
        end else if (state == S_FAULT && !stall) begin
            instr          <= NOP_INSTR;
            instr_pc       <= pc;
            instr_valid    <= 1'b1;
            instr_misalign <= 1'b1;
`endif
        end else if (!stall) begin
            instr          <= NOP_INSTR;
            instr_valid    <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            instr_misalign <= 1'b0;
`endif
        end
    end

endmodule
